// File: rtl/alu_param_pkg.sv
// alu_param_pkg: shared types for the parametrised multi-cycle ALU.
//   alu_op_t    - 4-bit opcode set (logic, arithmetic, shift/rotate, MULT)
//   alu_movi_t  - operand B source select
//   alu_state_t - control FSM states (MUL exists only when ALU_MULT_EN is defined)
package alu_param_pkg;

  localparam int ALU_WIDTH_MIN = 4;
  localparam int ALU_WIDTH_MAX = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MULT = 4'd2,
    OP_SHL  = 4'd3,
    OP_SHR  = 4'd4,
    OP_ROL  = 4'd5,
    OP_ROR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NAND = 4'd11,
    OP_NOR  = 4'd12,
    OP_XNOR = 4'd13,
    OP_INC  = 4'd14,
    OP_DEC  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    MOVI_REG_B     = 2'b00,
    MOVI_MEM       = 2'b01,
    MOVI_IMM       = 2'b10,
    MOVI_REG_B_ALT = 2'b11
  } alu_movi_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned multiplier, one partial product
// per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load a/b and begin (ignored while busy)
//   a, b     : W-bit unsigned operands, sampled on the start edge
//   busy     : an operation is in progress
//   done     : final product is on prod this cycle (last busy cycle)
//   prod     : 2W-bit product (valid when done)
// Bit 0 of b is folded in on the start edge, so after W-1 more edges the
// product is complete and done is raised; busy drops on the following edge,
// giving a start-to-capture latency of W cycles.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      acc    <= b[0] ? {{W{1'b0}}, a} : '0;
      mcand  <= {{(W-1){1'b0}}, a, 1'b0};
      mplier <= {1'b0, b[W-1:1]};
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt == LAST) begin
        busy_q <= 1'b0;
      end else begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= {mcand[2*W-2:0], 1'b0};
        mplier <= {1'b0, mplier[W-1:1]};
        cnt    <= cnt + CW'(1);
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == LAST);
  assign prod = acc;

endmodule

// File: rtl/alu_param_mc.sv
// alu_param_mc: parametrised multi-cycle ALU.
//   CLK, RST       : clock, asynchronous active-high reset
//   ACT, ALU_RDY   : request / ready handshake
//   OP, MOVI       : opcode (alu_op_t), operand B source (alu_movi_t)
//   REG_A          : operand A
//   REG_B/MEM/IMM  : operand B candidates
//   EX_ALU         : 2*DATA_WIDTH result, held between strobes
//   EX_ALU_VLD     : one-cycle result strobe
// Handshake: an operation is accepted on a rising edge where ACT=1 and
// ALU_RDY=1; all operands are sampled on that edge only. ACT while ALU_RDY=0
// is dropped, not queued, so the requester must keep ACT high until accepted.
// Build option ALU_MULT_EN: when defined, MULT runs on the iterative
// multiplier (W cycles, ALU_RDY low). When undefined, MULT completes in one
// cycle with a zero result and ALU_RDY is constant 1.
module alu_param_mc
  import alu_param_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ACT,
  input  logic [3:0]              OP,
  input  logic [1:0]              MOVI,
  input  logic [DATA_WIDTH-1:0]   REG_A,
  input  logic [DATA_WIDTH-1:0]   REG_B,
  input  logic [DATA_WIDTH-1:0]   MEM,
  input  logic [DATA_WIDTH-1:0]   IMM,
  output logic                    ALU_RDY,
  output logic [2*DATA_WIDTH-1:0] EX_ALU,
  output logic                    EX_ALU_VLD
);

  localparam int W = DATA_WIDTH;

  alu_op_t      op;
  alu_movi_t    movi;
  logic [W-1:0] opnd_b;
  logic         accept;

  assign op     = alu_op_t'(OP);
  assign movi   = alu_movi_t'(MOVI);
  assign accept = ACT && ALU_RDY;

  always_comb begin
    opnd_b = REG_B;
    case (movi)
      MOVI_MEM: opnd_b = MEM;
      MOVI_IMM: opnd_b = IMM;
      default:  opnd_b = REG_B;
    endcase
  end

  // Arithmetic is done one bit wider so bit W carries the carry/borrow.
  logic [W:0] add_ext, sub_ext, inc_ext, dec_ext;
  assign add_ext = {1'b0, REG_A} + {1'b0, opnd_b};
  assign sub_ext = {1'b0, REG_A} - {1'b0, opnd_b};
  assign inc_ext = {1'b0, REG_A} + (W+1)'(1);
  assign dec_ext = {1'b0, REG_A} - (W+1)'(1);

  logic [2*W-1:0] result;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = {{(W-1){1'b0}}, add_ext};
      OP_SUB:  result = {{(W-1){1'b0}}, sub_ext};
      OP_INC:  result = {{(W-1){1'b0}}, inc_ext};
      OP_DEC:  result = {{(W-1){1'b0}}, dec_ext};
      OP_SHL:  result = {{W{1'b0}}, REG_A[W-2:0], 1'b0};
      OP_SHR:  result = {{W{1'b0}}, 1'b0, REG_A[W-1:1]};
      OP_ROL:  result = {{W{1'b0}}, REG_A[W-2:0], REG_A[W-1]};
      OP_ROR:  result = {{W{1'b0}}, REG_A[0], REG_A[W-1:1]};
      OP_NOT:  result = {{W{1'b0}}, ~REG_A};
      OP_AND:  result = {{W{1'b0}}, REG_A & opnd_b};
      OP_OR:   result = {{W{1'b0}}, REG_A | opnd_b};
      OP_XOR:  result = {{W{1'b0}}, REG_A ^ opnd_b};
      OP_NAND: result = {{W{1'b0}}, ~(REG_A & opnd_b)};
      OP_NOR:  result = {{W{1'b0}}, ~(REG_A | opnd_b)};
      OP_XNOR: result = {{W{1'b0}}, ~(REG_A ^ opnd_b)};
      // MULT is either produced by the sequencer or defined as zero.
      default: result = '0;
    endcase
  end

  logic           mul_start;
  logic           mul_fin;
  logic [2*W-1:0] mul_prod;

`ifdef ALU_MULT_EN
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  alu_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic           mul_busy;
  logic           mul_done;

  assign mul_start = accept && (op == OP_MULT);

  alu_mul_seq #(.W(W)) u_mul (
    .clk   (CLK),
    .rst   (RST),
    .start (mul_start),
    .a     (REG_A),
    .b     (opnd_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mul_fin   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mul_start) begin
          state_nxt = ST_MUL;
          cnt_nxt   = '0;
        end
      end
      ST_MUL: begin
        // The FSM count and the multiplier's done flag line up on the
        // W-th cycle; that is the capture edge for the product.
        if (cnt == LAST && mul_done) begin
          mul_fin   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Never offer ready while the multiplier still holds an operation.
  assign ALU_RDY = (state == ST_IDLE) && !mul_busy;
`else
  assign mul_start = 1'b0;
  assign mul_fin   = 1'b0;
  assign mul_prod  = '0;
  assign ALU_RDY   = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EX_ALU     <= '0;
      EX_ALU_VLD <= 1'b0;
    end else if (mul_fin) begin
      EX_ALU     <= mul_prod;
      EX_ALU_VLD <= 1'b1;
    end else if (accept && !mul_start) begin
      EX_ALU     <= result;
      EX_ALU_VLD <= 1'b1;
    end else begin
      EX_ALU_VLD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_param_mc.sv
// tb_alu_param_mc: self-checking bench for alu_param_mc. Two instances are
// used: DATA_WIDTH=8 (directed, MULT, reset, random) and DATA_WIDTH=16
// (back-to-back and random single-cycle ops). Follows ALU_MULT_EN.
module tb_alu_param_mc;

  logic clk = 1'b0;
  logic rst;

  logic        act8;
  logic [3:0]  op8;
  logic [1:0]  movi8;
  logic [7:0]  a8, b8, mem8, imm8;
  logic        rdy8;
  logic [15:0] res8;
  logic        vld8;

  logic        act16;
  logic [3:0]  op16;
  logic [1:0]  movi16;
  logic [15:0] a16, b16, mem16, imm16;
  logic        rdy16;
  logic [31:0] res16;
  logic        vld16;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  alu_param_mc #(.DATA_WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .ACT(act8), .OP(op8), .MOVI(movi8),
    .REG_A(a8), .REG_B(b8), .MEM(mem8), .IMM(imm8),
    .ALU_RDY(rdy8), .EX_ALU(res8), .EX_ALU_VLD(vld8)
  );

  alu_param_mc #(.DATA_WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst), .ACT(act16), .OP(op16), .MOVI(movi16),
    .REG_A(a16), .REG_B(b16), .MEM(mem16), .IMM(imm16),
    .ALU_RDY(rdy16), .EX_ALU(res16), .EX_ALU_VLD(vld16)
  );

  // Reference model: unsigned arithmetic on the spec's width rules.
  function automatic logic [63:0] ref_alu(input int w, input int op, input int movi,
                                          input logic [31:0] a, input logic [31:0] rb,
                                          input logic [31:0] mem, input logic [31:0] imm);
    logic [63:0] full, m, x, y;
    full = 64'd1 << w;
    m    = full - 64'd1;
    x    = {32'd0, a} & m;
    case (movi)
      1:       y = {32'd0, mem} & m;
      2:       y = {32'd0, imm} & m;
      default: y = {32'd0, rb} & m;
    endcase
    case (op)
      0:  return x + y;
      1:  return ((x < y) ? full : 64'd0) + ((x - y) & m);
`ifdef ALU_MULT_EN
      2:  return x * y;
`else
      2:  return 64'd0;
`endif
      3:  return (x << 1) & m;
      4:  return x >> 1;
      5:  return ((x << 1) | (x >> (w - 1))) & m;
      6:  return (x >> 1) | ((x & 64'd1) << (w - 1));
      7:  return ~x & m;
      8:  return x & y;
      9:  return x | y;
      10: return x ^ y;
      11: return ~(x & y) & m;
      12: return ~(x | y) & m;
      13: return ~(x ^ y) & m;
      14: return x + 64'd1;
      15: return ((x < 64'd1) ? full : 64'd0) + ((x - 64'd1) & m);
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input int op, input int movi, input logic [31:0] a,
                        input logic [31:0] rb, input logic [31:0] mem, input logic [31:0] imm);
    act8 = 1'b1; op8 = op[3:0]; movi8 = movi[1:0];
    a8 = a[7:0]; b8 = rb[7:0]; mem8 = mem[7:0]; imm8 = imm[7:0];
  endtask

  task automatic drive16(input int op, input int movi, input logic [31:0] a,
                         input logic [31:0] rb, input logic [31:0] mem, input logic [31:0] imm);
    act16 = 1'b1; op16 = op[3:0]; movi16 = movi[1:0];
    a16 = a[15:0]; b16 = rb[15:0]; mem16 = mem[15:0]; imm16 = imm[15:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    act8 = 0; op8 = 0; movi8 = 0; a8 = 0; b8 = 0; mem8 = 0; imm8 = 0;
    act16 = 0; op16 = 0; movi16 = 0; a16 = 0; b16 = 0; mem16 = 0; imm16 = 0;
    repeat (2) tick();
    checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset_rdy8: got %b expected 1", rdy8); end
    checks++; if (res8 !== 16'h0) begin errors++; $display("FAIL reset_res8: got %h expected 0000", res8); end
    checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL reset_vld8: got %b expected 0", vld8); end
    checks++; if (rdy16 !== 1'b1 || vld16 !== 1'b0 || res16 !== 32'h0) begin
      errors++; $display("FAIL reset_dut16: got rdy=%b vld=%b res=%h expected 1 0 0", rdy16, vld16, res16);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub_dec();
    drive8(0, 2, 32'hFF, 32'h00, 32'h00, 32'h01);
    tick();
    checks++; if (vld8 !== 1'b1 || res8 !== 16'h0100) begin
      errors++; $display("FAIL add_carry: got vld=%b res=%h expected 1 0100", vld8, res8);
    end
    act8 = 1'b0;
    tick();
    checks++; if (vld8 !== 1'b0 || res8 !== 16'h0100) begin
      errors++; $display("FAIL add_vld_pulse_hold: got vld=%b res=%h expected 0 0100", vld8, res8);
    end
    drive8(1, 1, 32'h03, 32'hAA, 32'h05, 32'h77);
    tick();
    checks++; if (vld8 !== 1'b1 || res8 !== 16'h01FE) begin
      errors++; $display("FAIL sub_borrow: got vld=%b res=%h expected 1 01fe", vld8, res8);
    end
    drive8(15, 0, 32'h00, 32'h33, 32'h44, 32'h55);
    tick();
    checks++; if (vld8 !== 1'b1 || res8 !== 16'h01FF) begin
      errors++; $display("FAIL dec_borrow: got vld=%b res=%h expected 1 01ff", vld8, res8);
    end
    act8 = 1'b0;
    tick();
  endtask

  task automatic test_mult();
`ifdef ALU_MULT_EN
    drive8(2, 0, 32'hFF, 32'hFF, 32'h00, 32'h00);
    tick(); // accept edge k
    checks++; if (rdy8 !== 1'b0 || vld8 !== 1'b0) begin
      errors++; $display("FAIL mult_start: got rdy=%b vld=%b expected 0 0", rdy8, vld8);
    end
    // Request held while busy: must be ignored until ready returns.
    drive8(0, 0, 32'h01, 32'h02, 32'h00, 32'h00);
    for (int j = 1; j < 8; j++) begin
      tick();
      checks++; if (rdy8 !== 1'b0 || vld8 !== 1'b0) begin
        errors++; $display("FAIL mult_busy_%0d: got rdy=%b vld=%b expected 0 0", j, rdy8, vld8);
      end
    end
    tick(); // edge k+8
    checks++; if (vld8 !== 1'b1 || res8 !== 16'hFE01 || rdy8 !== 1'b1) begin
      errors++; $display("FAIL mult_done: got vld=%b res=%h rdy=%b expected 1 fe01 1", vld8, res8, rdy8);
    end
    tick(); // edge k+9 accepts the held ADD
    checks++; if (vld8 !== 1'b1 || res8 !== 16'h0003) begin
      errors++; $display("FAIL mult_next_accept: got vld=%b res=%h expected 1 0003", vld8, res8);
    end
    act8 = 1'b0;
    tick();
    checks++; if (vld8 !== 1'b0) begin
      errors++; $display("FAIL mult_after_idle: got vld=%b expected 0", vld8);
    end
`else
    drive8(2, 0, 32'hFF, 32'hFF, 32'h00, 32'h00);
    checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL mult_off_rdy_pre: got %b expected 1", rdy8); end
    tick();
    checks++; if (vld8 !== 1'b1 || res8 !== 16'h0000 || rdy8 !== 1'b1) begin
      errors++; $display("FAIL mult_off_result: got vld=%b res=%h rdy=%b expected 1 0000 1", vld8, res8, rdy8);
    end
    act8 = 1'b0;
    tick();
    checks++; if (vld8 !== 1'b0 || rdy8 !== 1'b1) begin
      errors++; $display("FAIL mult_off_after: got vld=%b rdy=%b expected 0 1", vld8, rdy8);
    end
`endif
  endtask

  task automatic test_back_to_back();
    drive16(5, 0, 32'h8001, 32'h0, 32'h0, 32'h0);
    tick();
    checks++; if (vld16 !== 1'b1 || res16 !== 32'h0000_0003) begin
      errors++; $display("FAIL b2b_rol: got vld=%b res=%h expected 1 00000003", vld16, res16);
    end
    drive16(13, 0, 32'h00FF, 32'h0F0F, 32'h0, 32'h0);
    tick();
    checks++; if (vld16 !== 1'b1 || res16 !== 32'h0000_F00F) begin
      errors++; $display("FAIL b2b_xnor: got vld=%b res=%h expected 1 0000f00f", vld16, res16);
    end
    act16 = 1'b0;
    tick();
    checks++; if (vld16 !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got vld=%b expected 0", vld16);
    end
  endtask

  task automatic test_reset_mid_op();
`ifdef ALU_MULT_EN
    drive8(2, 0, 32'hC3, 32'h5D, 32'h0, 32'h0);
`else
    drive8(10, 0, 32'h5A, 32'h0F, 32'h0, 32'h0);
`endif
    tick();
    act8 = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++; if (rdy8 !== 1'b1 || res8 !== 16'h0 || vld8 !== 1'b0) begin
      errors++; $display("FAIL rst_async: got rdy=%b res=%h vld=%b expected 1 0000 0", rdy8, res8, vld8);
    end
    drive8(0, 2, 32'h10, 32'h0, 32'h0, 32'h22);
    tick();
    checks++; if (vld8 !== 1'b0 || res8 !== 16'h0) begin
      errors++; $display("FAIL rst_held: got vld=%b res=%h expected 0 0000", vld8, res8);
    end
    rst = 1'b0;
    tick();
    checks++; if (vld8 !== 1'b1 || res8 !== 16'h0032) begin
      errors++; $display("FAIL rst_first_accept: got vld=%b res=%h expected 1 0032", vld8, res8);
    end
    act8 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++; if (vld8 !== 1'b0 || res8 !== 16'h0032) begin
        errors++; $display("FAIL rst_no_stale_%0d: got vld=%b res=%h expected 0 0032", j, vld8, res8);
      end
    end
  endtask

  task automatic test_random8();
    int op, movi;
    logic [31:0] ra, rb, rm, ri;
    logic [63:0] e;
    logic [15:0] want;
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15); movi = $urandom_range(0, 3);
      ra = $urandom; rb = $urandom; rm = $urandom; ri = $urandom;
      e = ref_alu(8, op, movi, ra, rb, rm, ri);
      exp_q.push_back(e[15:0]);
      drive8(op, movi, ra, rb, rm, ri);
      tick();
`ifdef ALU_MULT_EN
      if (op == 2) begin
        act8 = 1'b0;
        for (int j = 1; j < 8; j++) begin
          a8 = 8'($urandom); b8 = 8'($urandom); mem8 = 8'($urandom);
          imm8 = 8'($urandom); op8 = 4'($urandom);
          tick();
          checks++; if (vld8 !== 1'b0) begin
            errors++; $display("FAIL rand8_mul_busy %0d: got vld=%b expected 0", i, vld8);
          end
        end
        tick();
        checks++; if (rdy8 !== 1'b1) begin
          errors++; $display("FAIL rand8_mul_rdy %0d: got %b expected 1", i, rdy8);
        end
      end
`endif
      want = exp_q.pop_front();
      checks++; if (vld8 !== 1'b1 || res8 !== want) begin
        errors++; $display("FAIL rand8 %0d op=%0d: got vld=%b res=%h expected 1 %h", i, op, vld8, res8, want);
      end
      if ($urandom_range(0, 3) == 0) begin
        act8 = 1'b0;
        tick();
      end
    end
    act8 = 1'b0;
    tick();
  endtask

  task automatic test_random16();
    int op, movi;
    logic [31:0] ra, rb, rm, ri;
    logic [63:0] e;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      if (op == 2) op = 10;
      movi = $urandom_range(0, 3);
      ra = $urandom; rb = $urandom; rm = $urandom; ri = $urandom;
      e = ref_alu(16, op, movi, ra, rb, rm, ri);
      drive16(op, movi, ra, rb, rm, ri);
      tick();
      checks++; if (vld16 !== 1'b1 || res16 !== e[31:0]) begin
        errors++; $display("FAIL rand16 %0d op=%0d: got vld=%b res=%h expected 1 %h", i, op, vld16, res16, e[31:0]);
      end
    end
    act16 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add_sub_dec();
    test_mult();
    test_back_to_back();
    test_reset_mid_op();
    test_random8();
    test_random16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
